// File: rtl/scheduler_pkg.sv
// scheduler_pkg: opcode classes, scheduler states and operand-use decode for decode_scoreboard_scheduler.
package scheduler_pkg;
  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_ALU_LO = 4'd1;
  localparam logic [3:0] OP_ALU_HI = 4'd7;
  localparam logic [3:0] OP_IMM_LO = 4'd8;
  localparam logic [3:0] OP_IMM_HI = 4'd9;
  localparam logic [3:0] OP_LOAD   = 4'd10;
  localparam logic [3:0] OP_STORE  = 4'd11;
  localparam logic [3:0] OP_BR_LO  = 4'd12;
  localparam logic [3:0] OP_BR_HI  = 4'd14;
  localparam logic [3:0] OP_HALT   = 4'd15;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} sched_state_t;

  typedef struct packed {
    logic usesR1;
    logic usesR2;
    logic writesDest;
  } op_use_t;

  function automatic op_use_t decode_use(input logic [3:0] op);
    logic alu, imm, br;
    alu = op >= OP_ALU_LO && op <= OP_ALU_HI;
    imm = op >= OP_IMM_LO && op <= OP_IMM_HI;
    br  = op >= OP_BR_LO && op <= OP_BR_HI;
    decode_use.usesR1     = alu | br | op == OP_LOAD | op == OP_STORE;
    decode_use.usesR2     = alu | br | op == OP_STORE;
    decode_use.writesDest = alu | imm | op == OP_LOAD;
  endfunction
endpackage

// File: rtl/scoreboard_counters.sv
// scoreboard_counters: per-register pending-write counters with sticky underflow flag.
// SCOREBOARD_BYPASS_EN: eff_o already reflects this cycle's writeback.
module scoreboard_counters #(
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int CNTWIDTH     = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             inc_i,
  input  logic [ADDRESSWIDTH-1:0]          inc_addr_i,
  input  logic                             dec_i,
  input  logic [ADDRESSWIDTH-1:0]          dec_addr_i,
  output logic [REGNUM-1:0][CNTWIDTH-1:0]  eff_o,
  output logic                             all_zero_o,
  output logic                             underflow_o
);
  logic [REGNUM-1:0][CNTWIDTH-1:0] pend_q, pend_d;
  logic err_q, err_d, dec_ok;

  assign dec_ok      = dec_i & (pend_q[dec_addr_i] != '0);
  assign err_d       = err_q | (dec_i & (pend_q[dec_addr_i] == '0));
  assign underflow_o = err_q;

  // all_zero_o looks at the post-writeback count so DRAIN can exit the same cycle
  always_comb begin
    all_zero_o = 1'b1;
    for (int r = 0; r < REGNUM; r++) begin
      pend_d[r] = pend_q[r] + CNTWIDTH'(inc_i && inc_addr_i == ADDRESSWIDTH'(r))
                            - CNTWIDTH'(dec_ok && dec_addr_i == ADDRESSWIDTH'(r));
`ifdef SCOREBOARD_BYPASS_EN
      eff_o[r] = pend_q[r] - CNTWIDTH'(dec_ok && dec_addr_i == ADDRESSWIDTH'(r));
`else
      eff_o[r] = pend_q[r];
`endif
      all_zero_o &= pend_d[r] == '0;
    end
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
endmodule

// File: rtl/decode_scoreboard_scheduler.sv
// decode_scoreboard_scheduler: RAW/WAW hazard issue gating plus HALT drain sequencing.
// Optional SCOREBOARD_BYPASS_EN lets a same-cycle writeback unblock decode.
module decode_scoreboard_scheduler
  import scheduler_pkg::*;
#(
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int OPCODEWIDTH  = 4,
  parameter int CNTWIDTH     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    decValid,
  input  logic [OPCODEWIDTH-1:0]  opcode,
  input  logic [ADDRESSWIDTH-1:0] reg1Address,
  input  logic [ADDRESSWIDTH-1:0] reg2Address,
  input  logic [ADDRESSWIDTH-1:0] regDestinationAddress,
  input  logic                    wbValid,
  input  logic [ADDRESSWIDTH-1:0] wbAddress,
  input  logic                    resume,
  output logic                    issue,
  output logic                    stall,
  output logic                    draining,
  output logic                    halted,
  output logic                    errUnderflow
);
  sched_state_t state_q, state_d;
  op_use_t use_w;
  logic [3:0] op4;
  logic [REGNUM-1:0][CNTWIDTH-1:0] eff;
  logic hazard, all_zero;

  assign op4   = 4'(opcode);
  assign use_w = decode_use(op4);

  scoreboard_counters #(
    .REGNUM(REGNUM), .ADDRESSWIDTH(ADDRESSWIDTH), .CNTWIDTH(CNTWIDTH)
  ) u_sb (
    .clock(clock), .reset(reset),
    .inc_i(issue & use_w.writesDest), .inc_addr_i(regDestinationAddress),
    .dec_i(wbValid), .dec_addr_i(wbAddress),
    .eff_o(eff), .all_zero_o(all_zero), .underflow_o(errUnderflow)
  );

  assign hazard = (use_w.usesR1 & (eff[reg1Address] != '0))
                | (use_w.usesR2 & (eff[reg2Address] != '0))
                | (use_w.writesDest & (eff[regDestinationAddress] == '1));
  // reset gates decValid so outputs drop the instant reset asserts
  assign issue = reset & decValid & (state_q == RUN) & ~hazard;
  assign stall = reset & decValid & ~issue;

  always_ff @(posedge clock or negedge reset)
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;

  always_comb
    state_d = state_q == RUN   ? ((issue && op4 == OP_HALT) ? DRAIN : RUN)
            : state_q == DRAIN ? (all_zero ? HALTED : DRAIN)
            :                    (resume ? RUN : HALTED);

  always_comb begin
    draining = state_q == DRAIN;
    halted   = state_q == HALTED;
  end
endmodule

// File: tb/tb_decode_scoreboard_scheduler.sv
// tb_decode_scoreboard_scheduler: directed vectors for hazard gating, saturation, HALT drain, underflow, reset.
module tb_decode_scoreboard_scheduler;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 0, reset = 0, decValid = 0, wbValid = 0, resume = 0;
  logic [3:0] opcode = 0, reg1Address = 0, reg2Address = 0, regDestinationAddress = 0, wbAddress = 0;
  logic issue, stall, draining, halted, errUnderflow;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  decode_scoreboard_scheduler dut (
    .clock(clock), .reset(reset), .decValid(decValid), .opcode(opcode),
    .reg1Address(reg1Address), .reg2Address(reg2Address),
    .regDestinationAddress(regDestinationAddress), .wbValid(wbValid),
    .wbAddress(wbAddress), .resume(resume), .issue(issue), .stall(stall),
    .draining(draining), .halted(halted), .errUnderflow(errUnderflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic dec(input logic v, input logic [3:0] op, input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] d);
    decValid = v;
    opcode = op;
    reg1Address = r1;
    reg2Address = r2;
    regDestinationAddress = d;
  endtask

  initial begin
    dec(1, 1, 2, 3, 5);
    #3;
    check("rst_issue", issue, 0);
    check("rst_stall", stall, 0);
    check("rst_draining", draining, 0);
    check("rst_halted", halted, 0);
    check("rst_err", errUnderflow, 0);
    decValid = 0;
    @(posedge clock);
    #3 reset = 1;
    tick;
    dec(1, 1, 2, 3, 5);
    #1 check("alu_issue", issue, 1);
    check("alu_nostall", stall, 0);
    tick;
    dec(1, 1, 5, 0, 6);
    #1 check("raw_stall", stall, 1);
    check("raw_noissue", issue, 0);
    wbValid = 1;
    wbAddress = 5;
    #1 check("raw_wb_cycle", issue, BYP);
    tick;
    wbValid = 0;
    #1 check("raw_after_wb", issue, 1);
    tick;
    decValid = 0;
    for (int i = 0; i < (BYP ? 2 : 1); i++) begin
      wbValid = 1;
      wbAddress = 6;
      tick;
    end
    wbValid = 0;
    for (int i = 0; i < 3; i++) begin
      dec(1, 8, 0, 0, 7);
      #1 check("waw_issue", issue, 1);
      tick;
    end
    #1 check("waw_sat_stall", stall, 1);
    wbValid = 1;
    wbAddress = 7;
    #1 check("waw_wb_cycle", issue, BYP);
    tick;
    wbValid = 0;
    #1 check("waw_after_wb", issue, !BYP);
    tick;
    #1 check("waw_resat", stall, 1);
    decValid = 0;
    for (int i = 0; i < 3; i++) begin
      wbValid = 1;
      wbAddress = 7;
      tick;
    end
    wbValid = 0;
    dec(1, 1, 0, 0, 4);
    tick;
    dec(1, 15, 0, 0, 0);
    #1 check("halt_issue", issue, 1);
    tick;
    dec(1, 1, 0, 0, 1);
    resume = 1;
    #1 check("drain_flag", draining, 1);
    check("drain_noissue", issue, 0);
    check("drain_stall", stall, 1);
    tick;
    resume = 0;
    #1 check("drain_resume_ign", draining, 1);
    wbValid = 1;
    wbAddress = 4;
    #1 check("drain_not_halted", halted, 0);
    tick;
    wbValid = 0;
    #1 check("halted_flag", halted, 1);
    check("halted_nodrain", draining, 0);
    check("halted_noissue", issue, 0);
    resume = 1;
    tick;
    resume = 0;
    #1 check("resume_run", halted, 0);
    check("resume_issue", issue, 1);
    tick;
    decValid = 0;
    wbValid = 1;
    wbAddress = 1;
    tick;
    wbValid = 0;
    #1 check("uf_pre", errUnderflow, 0);
    wbValid = 1;
    wbAddress = 9;
    tick;
    wbValid = 0;
    #1 check("uf_set", errUnderflow, 1);
    tick;
    check("uf_sticky", errUnderflow, 1);
    dec(1, 1, 9, 9, 3);
    #1 check("uf_pend_zero", issue, 1);
    decValid = 0;
    tick;
    dec(1, 15, 0, 0, 0);
    #1 check("halt0_issue", issue, 1);
    tick;
    decValid = 0;
    #1 check("halt0_drain", draining, 1);
    tick;
    check("halt0_halted", halted, 1);
    check("halt0_nodrain", draining, 0);
    resume = 1;
    tick;
    resume = 0;
    dec(1, 8, 0, 0, 2);
    tick;
    tick;
    dec(1, 15, 0, 0, 0);
    tick;
    dec(1, 1, 2, 2, 3);
    #1 check("mid_drain", draining, 1);
    check("mid_stall", stall, 1);
    reset = 0;
    #1 check("arst_draining", draining, 0);
    check("arst_halted", halted, 0);
    check("arst_issue", issue, 0);
    check("arst_stall", stall, 0);
    check("arst_err", errUnderflow, 0);
    #1 reset = 1;
    #1 check("post_rst_issue", issue, 1);
    check("post_rst_stall", stall, 0);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
